// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-subset CPU: one state per clock,
// Moore-decoded selects/enables plus a zero-resolved PC write in BRANCH.
module multicycle_control #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic            zero,
    output logic [ST_W-1:0] state,
    output logic            pc_we,
    output logic            iord,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            ir_we,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_we,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_op,
    output logic [1:0]      pc_src
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EX   = 4'd10,
        S_IMM_WB   = 4'd11,
        S_JR       = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] FN_JR    = 6'h08;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        w_next     = S_FETCH;
        pc_we      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        pc_src     = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                ir_we     = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b010;
                pc_we     = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_b = 2'b11;
                alu_op    = 3'b010;
                case (opcode)
                    OP_LW, OP_SW:                     w_next = S_MEMADDR;
                    OP_RTYPE:                         w_next = (funct == FN_JR) ? S_JR : S_RTYPE_EX;
                    OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
                    OP_J:                             w_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IMM_EX;
                    default:                          w_next = S_FETCH;
                endcase
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
                w_next    = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                w_next    = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_src    = 2'b01;
                pc_we     = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            S_IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
                w_next    = S_IMM_WB;
                case (opcode)
                    OP_ANDI: alu_op = 3'b100;
                    OP_ORI:  alu_op = 3'b101;
                    OP_SLTI: alu_op = 3'b110;
                    default: alu_op = 3'b010;
                endcase
            end
            S_IMM_WB: begin
                reg_we = 1'b1;
            end
            S_JR: begin
                pc_src = 2'b11;
                pc_we  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state sequences and per-state
// control outputs for every instruction class, reset and a random stream.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic [3:0] state;
    logic       pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.OP_W(6), .ST_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .state(state), .pc_we(pc_we), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ir_we(ir_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        opcode = 6'h23;
        #1 rst = 1'b1;
        #2;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if ({mem_rd, ir_we, pc_we, alu_op, alu_src_b} !== {1'b1, 1'b1, 1'b1, 3'b010, 2'b01}) begin
            errors++; $display("FAIL rst_fetch_outs got %b exp 1110101", {mem_rd, ir_we, pc_we, alu_op, alu_src_b}); end
        @(posedge clk); #1 rst = 1'b0;
        step();
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL rst_first_edge got %0d exp 1", state); end
        step(); step();
        checks++; if (state !== 4'd3) begin errors++; $display("FAIL rst_pre_memread got %0d exp 3", state); end
        #3 rst = 1'b1;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_async got %0d exp 0", state); end
        checks++; if ({iord, mem_rd, ir_we, pc_we, alu_op} !== {1'b0, 1'b1, 1'b1, 1'b1, 3'b010}) begin
            errors++; $display("FAIL rst_async_outs got %b exp 0111010", {iord, mem_rd, ir_we, pc_we, alu_op}); end
        @(posedge clk); #1 rst = 1'b0;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_hold got %0d exp 0", state); end
    endtask

    task automatic test_lw();
        opcode = 6'h23; funct = 6'h00;
        step();
        checks++; if (state !== 4'd1 || alu_src_b !== 2'b11 || alu_op !== 3'b010) begin
            errors++; $display("FAIL lw_decode got st=%0d srcb=%b op=%b exp 1/11/010", state, alu_src_b, alu_op); end
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL lw_decode_regwe got %b exp 0", reg_we); end
        step();
        checks++; if (state !== 4'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 3'b010) begin
            errors++; $display("FAIL lw_memaddr got st=%0d a=%b b=%b op=%b exp 2/1/10/010", state, alu_src_a, alu_src_b, alu_op); end
        step();
        opcode = 6'h2B;
        checks++; if (state !== 4'd3 || iord !== 1'b1 || mem_rd !== 1'b1 || reg_we !== 1'b0 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL lw_memread got st=%0d iord=%b rd=%b we=%b wr=%b exp 3/1/1/0/0", state, iord, mem_rd, reg_we, mem_wr); end
        step();
        checks++; if (state !== 4'd4 || reg_we !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
            errors++; $display("FAIL lw_memwb got st=%0d we=%b m2r=%b dst=%b exp 4/1/1/0", state, reg_we, mem_to_reg, reg_dst); end
        step();
        checks++; if (state !== 4'd0 || reg_we !== 1'b0) begin errors++; $display("FAIL lw_done got st=%0d we=%b exp 0/0", state, reg_we); end
    endtask

    task automatic test_sw();
        opcode = 6'h2B;
        step(); step(); step();
        checks++; if (state !== 4'd5 || mem_wr !== 1'b1 || iord !== 1'b1 || mem_rd !== 1'b0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL sw_memwrite got st=%0d wr=%b iord=%b rd=%b we=%b exp 5/1/1/0/0", state, mem_wr, iord, mem_rd, reg_we); end
        step();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_done got %0d exp 0", state); end
    endtask

    task automatic test_rtype();
        opcode = 6'h00; funct = 6'h20;
        step(); step();
        checks++; if (state !== 4'd6 || alu_op !== 3'b000 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
            errors++; $display("FAIL rtype_ex got st=%0d op=%b a=%b b=%b exp 6/000/1/00", state, alu_op, alu_src_a, alu_src_b); end
        funct = 6'h08;
        step();
        checks++; if (state !== 4'd7 || reg_dst !== 1'b1 || reg_we !== 1'b1) begin
            errors++; $display("FAIL rtype_wb got st=%0d dst=%b we=%b exp 7/1/1", state, reg_dst, reg_we); end
        step();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rtype_done got %0d exp 0", state); end
    endtask

    task automatic test_jr();
        opcode = 6'h00; funct = 6'h08;
        step(); step();
        checks++; if (state !== 4'd12 || pc_src !== 2'b11 || pc_we !== 1'b1) begin
            errors++; $display("FAIL jr_state got st=%0d src=%b we=%b exp 12/11/1", state, pc_src, pc_we); end
        step();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL jr_done got %0d exp 0", state); end
        funct = 6'h00;
    endtask

    task automatic test_jump();
        opcode = 6'h02;
        step(); step();
        checks++; if (state !== 4'd9 || pc_src !== 2'b10 || pc_we !== 1'b1) begin
            errors++; $display("FAIL j_state got st=%0d src=%b we=%b exp 9/10/1", state, pc_src, pc_we); end
        step();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL j_done got %0d exp 0", state); end
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_we, input string nm);
        opcode = op; zero = ~z;
        step(); step();
        zero = z;
        #1;
        checks++; if (state !== 4'd8 || alu_op !== 3'b001 || pc_src !== 2'b01 || alu_src_a !== 1'b1) begin
            errors++; $display("FAIL %s_state got st=%0d op=%b src=%b a=%b exp 8/001/01/1", nm, state, alu_op, pc_src, alu_src_a); end
        checks++; if (pc_we !== exp_we) begin errors++; $display("FAIL %s_pcwe got %b exp %b", nm, pc_we, exp_we); end
        step();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL %s_done got %0d exp 0", nm, state); end
        zero = 1'b0;
    endtask

    task automatic test_imm(input logic [5:0] op, input logic [2:0] exp_op, input string nm);
        opcode = op;
        step(); step();
        checks++; if (state !== 4'd10 || alu_op !== exp_op || alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin
            errors++; $display("FAIL %s_ex got st=%0d op=%b a=%b b=%b exp 10/%b/1/10", nm, state, alu_op, alu_src_a, alu_src_b, exp_op); end
        step();
        checks++; if (state !== 4'd11 || reg_we !== 1'b1 || reg_dst !== 1'b0) begin
            errors++; $display("FAIL %s_wb got st=%0d we=%b dst=%b exp 11/1/0", nm, state, reg_we, reg_dst); end
        step();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL %s_done got %0d exp 0", nm, state); end
    endtask

    task automatic test_illegal();
        opcode = 6'h3F;
        checks++; if (reg_we !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL ill_fetch got we=%b wr=%b exp 0/0", reg_we, mem_wr); end
        step();
        checks++; if (state !== 4'd1 || reg_we !== 1'b0 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL ill_decode got st=%0d we=%b wr=%b exp 1/0/0", state, reg_we, mem_wr); end
        step();
        checks++; if (state !== 4'd0 || reg_we !== 1'b0 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL ill_done got st=%0d we=%b wr=%b exp 0/0/0", state, reg_we, mem_wr); end
    endtask

    task automatic test_random_stream();
        logic [5:0] ops [11];
        logic [5:0] fns [11];
        int         lat [11];
        int         k, n;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A};
        fns = '{6'h00, 6'h00, 6'h20, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        lat = '{5, 4, 4, 3, 3, 3, 3, 4, 4, 4, 4};
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 10);
            opcode = ops[k]; funct = fns[k];
            n = 0;
            do begin
                zero = 1'($urandom_range(0, 1));
                #1;
                checks++; if ((mem_rd & mem_wr) !== 1'b0 || (reg_we & mem_wr) !== 1'b0) begin
                    errors++; $display("FAIL mutex st=%0d rd=%b wr=%b we=%b exp no overlap", state, mem_rd, mem_wr, reg_we); end
                step();
                n++;
            end while (state !== 4'd0 && n < 8);
            checks++; if (n !== lat[k]) begin errors++; $display("FAIL latency op=%h fn=%h got %0d exp %0d", opcode, funct, n, lat[k]); end
        end
        zero = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_jr();
        test_jump();
        test_branch(6'h04, 1'b1, 1'b1, "beq_taken");
        test_branch(6'h04, 1'b0, 1'b0, "beq_not");
        test_branch(6'h05, 1'b0, 1'b1, "bne_taken");
        test_branch(6'h05, 1'b1, 1'b0, "bne_not");
        test_imm(6'h0D, 3'b101, "ori");
        test_imm(6'h0A, 3'b110, "slti");
        test_imm(6'h08, 3'b010, "addi");
        test_imm(6'h0C, 3'b100, "andi");
        test_illegal();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout reached exp finish before 50000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS-subset CPU. It sequences a shared ALU, memory and register file through the fetch, decode, execute, memory and writeback steps, one state per clock. It drives the 3-bit ALUOp consumed by the ALU function decoder, plus all mux selects and write enables. It sits beside the datapath and takes only the opcode, funct and ALU zero flag.

Parameters:
OP_W, 6, opcode/funct field width
ST_W, 4, state register width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, same-cycle combinational
state  out  4  current state, for debug/verification
pc_we  out  1  PC write enable (unconditional OR resolved branch)
iord  out  1  0=PC addresses memory, 1=ALUOut
mem_rd  out  1  memory read
mem_wr  out  1  memory write
ir_we  out  1  instruction register load
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
reg_we  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  3  000 R-type(funct), 001 sub, 010 add, 100 and, 101 or, 110 slt
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)

Behaviour:
- State register is the only storage. Reset asserted at any time forces FETCH(0) asynchronously; no partial instruction completes.
- Outputs are Moore: decoded from state only, except pc_we, which also uses zero and opcode in BRANCH. Default for every output in every state is 0, unless listed below.
- During reset, state=0 and outputs equal FETCH values. First fetch completes on the first rising edge after rst falls.
- States and outputs:
  - FETCH(0): mem_rd, ir_we, alu_src_b=01, alu_op=010, pc_src=00, pc_we=1. Next: DECODE.
  - DECODE(1): alu_src_b=11, alu_op=010. Next by opcode:
    - 0x23/0x2B -> MEMADDR
    - 0x00 with funct 0x08 -> JR
    - 0x00 other -> RTYPE_EX
    - 0x04/0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x08/0x0C/0x0D/0x0A -> IMM_EX
    - any other -> FETCH (illegal opcode treated as NOP; PC already advanced)
  - MEMADDR(2): alu_src_a=1, alu_src_b=10, alu_op=010. Next: MEMREAD if 0x23, else MEMWRITE.
  - MEMREAD(3): mem_rd, iord. Next: MEMWB.
  - MEMWB(4): reg_we, mem_to_reg, reg_dst=0. Next: FETCH.
  - MEMWRITE(5): mem_wr, iord. Next: FETCH.
  - RTYPE_EX(6): alu_src_a=1, alu_src_b=00, alu_op=000. Next: RTYPE_WB.
  - RTYPE_WB(7): reg_we, reg_dst=1. Next: FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01. pc_we=zero for 0x04, pc_we=~zero for 0x05. Next: FETCH.
  - JUMP(9): pc_src=10, pc_we=1. Next: FETCH.
  - IMM_EX(10): alu_src_a=1, alu_src_b=10. alu_op is 010 for 0x08, 100 for 0x0C, 101 for 0x0D, 110 for 0x0A. Next: IMM_WB.
  - IMM_WB(11): reg_we, reg_dst=0. Next: FETCH.
  - JR(12): pc_src=11, pc_we=1. Next: FETCH.
  - Codes 13-15 are unreachable; if entered they must return to FETCH with all outputs 0.
- Latency in cycles, fetch included:
  - lw 5
  - sw, R-type, addi/andi/ori/slti 4
  - beq, bne, j, jr 3
  - illegal 2
- opcode/funct are sampled only in DECODE, MEMADDR, BRANCH and IMM_EX. Changes in other states have no effect.
- mem_rd and mem_wr are never high together. reg_we and mem_wr are never high together.

Test Plan:
- Reset: rst=1 mid-MEMREAD -> state=0 immediately without waiting for clk. After release: mem_rd=1, ir_we=1, pc_we=1, alu_op=010.
- lw (opcode 0x23): state sequence 0,1,2,3,4,0. reg_we=1 only in state 4 with mem_to_reg=1. iord=1 in state 3.
- R-type add (opcode 0x00, funct 0x20): sequence 0,1,6,7,0. alu_op=000 in state 6, reg_dst=1 and reg_we=1 in state 7. With funct 0x08: sequence 0,1,12,0 with pc_src=11 and pc_we=1.
- Branch: beq with zero=1 -> pc_we=1 in state 8. beq with zero=0 -> pc_we=0. bne (0x05) with zero=0 -> pc_we=1. All cases return to state 0 next cycle.
- Immediates: ori (0x0D) -> alu_op=101 in state 10. slti (0x0A) -> alu_op=110 in state 10. reg_we=1 in state 11. Total 4 cycles each.
- Illegal opcode 0x3F -> sequence 0,1,0. reg_we and mem_wr stay 0 throughout. Assert mutual-exclusion properties on every cycle of a random legal-opcode stream.
